snoop_bus_ctrl: RTL
===================

// Module: snoop_bus_ctrl
// PURPOSE
//  Coherence bus controller between the two private dcaches and memory_control's data port.
//  Picks one cache transaction round-robin and snoops the other cache (MSI).
//  Sequences the 2-word block transfer: memory read, dirty writeback or cache-to-cache supply.
//  Presents a single word-serial dREN/dWEN/daddr/dstore request to memory_control and returns dload/dwait.
// PARAMETERS
//  CPUS      2   caches on the bus; only 2 is supported, elaborate-time assert otherwise
//  BLKWORDS  2   words per cache block; burst length of every block transfer
// PORTS
//  CLK             in   1          clock, rising edge
//  nRST            in   1          reset, asynchronous, active-low
//  dREN[CPUS]      in   1 each     cache read of a block word (miss fill)
//  dWEN[CPUS]      in   1 each     cache write of a block word (evict, or snoop supply)
//  daddr[CPUS]     in   32 each    word address from the cache
//  dstore[CPUS]    in   32 each    write data from the cache
//  cctrans[CPUS]   in   1 each     requester: coherence transaction; snoopee: snoop ack
//  ccwrite[CPUS]   in   1 each     requester: exclusive intent (BusRdX/upgrade); snoopee: holds M
//  dwait[CPUS]     out  1 each     1 = stall this cache's current word
//  dload[CPUS]     out  32 each    read data to the cache
//  ccwait[CPUS]    out  1 each     1 = cache is being snooped; freeze it
//  ccinv[CPUS]     out  1 each     1 = invalidate the snooped block
//  ccsnoopaddr[CPUS] out 32 each   address being snooped
//  mem_dREN        out  1          read request to memory_control
//  mem_dWEN        out  1          write request to memory_control
//  mem_daddr       out  32         word address to memory_control
//  mem_dstore      out  32         write data to memory_control
//  mem_dload       in   32         read data from memory_control
//  mem_dwait       in   1          0 = current word done this cycle
// BEHAVIOUR
//  Reset: state IDLE, grant ptr=0, word cnt=0.
//   dwait=all 1; dload, ccwait, ccinv, ccsnoopaddr, mem_* = 0.
//   Reset mid-transfer aborts it; no partial state persists.
//  Arbitration (IDLE): request = cctrans[i] | dWEN[i].
//   Both request: grant the CPU not served last. Ptr toggles only when the transaction reaches DONE.
//  FSM: IDLE -> SNOOP | WB -> ...
//   Requester = r, other = o.
//   dWEN[r] without cctrans[r]: WB (eviction).
//    Each word: mem_dWEN=1, mem_daddr=daddr[r], mem_dstore=dstore[r], dwait[r]=mem_dwait.
//    cnt++ on !mem_dwait. After BLKWORDS words -> DONE.
//   cctrans[r]: SNOOP.
//    ccwait[o]=1, ccsnoopaddr[o]=daddr[r], ccinv[o]=ccwrite[r]; held through DONE.
//    Waits for cctrans[o]=1; checked one cycle after entry at the earliest.
//    Then: !dREN[r] (upgrade S->M) -> DONE, no memory access.
//    Else ccwrite[o]=1 (o holds M) -> SUPPLY. Else -> MEMRD.
//   MEMRD: per word, mem_dREN=1, mem_daddr=daddr[r], dload[r]=mem_dload, dwait[r]=mem_dwait.
//    After BLKWORDS words -> DONE.
//   SUPPLY: see CONFIGURATION.
//   DONE: one cycle; all cc* deasserted, dwait all 1; -> IDLE.
//  Non-granted CPU always sees dwait=1.
//   Exception: snoopee's dWEN words in SUPPLY get dwait[o]=mem_dwait.
//  One transaction in flight. Latency/word = memory latency.
//   Overhead: 1 IDLE + >=1 SNOOP + 1 DONE cycle.
//  Both caches miss on the same block: loser is snooped first, then wins next round (serialised).
//  Word counter: clog2(BLKWORDS) bits; wraps to 0 at DONE.
// CONFIGURATION
//  C2C_FORWARD_EN defined: in SUPPLY, snoopee's dstore[o] goes to mem_dstore (mem_dWEN=1).
//   The same word goes to dload[r] in the same cycle.
//   dwait[r]=dwait[o]=mem_dwait. After BLKWORDS words -> DONE.
//  Undefined: SUPPLY writes o's block to memory (dwait[r]=1 throughout), then -> MEMRD for r.
// STRUCTURE
//  cpu_types_pkg gains:
//   - typedef enum logic [2:0] {IDLE,SNOOP,WB,MEMRD,SUPPLY,DONE} busstate_t
//   - localparam BLKWORDS_DEF=2
//  Reuses word_t.
//  Sub-module snoop_rr_arb: 2-way round-robin grant + last-grant flop (advance input).
// TESTING
//  1 CPU0 dREN+cctrans miss 0x100, CPU1 acks cctrans, ccwrite[1]=0
//    -> ccwait[1]=1, ccsnoopaddr[1]=0x100.
//    Then mem_dREN for 0x100 and 0x104; dload[0] returns RAM words.
//  2 CPU0 and CPU1 request in the same cycle after reset
//    -> CPU0 served first, then CPU1; a third CPU0 request waits behind CPU1.
//  3 CPU1 BusRdX 0x200 with CPU0 in M
//    -> ccinv[0]=1. C2C_FORWARD_EN: dload[1]==dstore[0] and RAM[0x200]=dstore[0].
//    Without it: RAM written first, then CPU1 reads back the same data.
//  4 CPU0 upgrade (cctrans+ccwrite, no dREN)
//    -> ccinv[1]=1, no mem_dREN/mem_dWEN asserted, DONE within 3 cycles of CPU1 ack.
//  5 CPU1 evict dWEN 0x300, data 0xDEAD/0xBEEF
//    -> mem_dWEN two words; RAM 0x300=0xDEAD, 0x304=0xBEEF; no ccwait.
//  6 nRST pulled low during MEMRD word 1
//    -> all outputs at reset values immediately; a new request after release completes normally.

Source files
------------

// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared types for the snooping coherence bus controller.
// Bus FSM state encoding, word type and default geometry.
package snoop_bus_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        WB,
        MEMRD,
        SUPPLY,
        DONE
    } busstate_t;

    localparam int CPUS_DEF     = 2;
    localparam int BLKWORDS_DEF = 2;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// Cache-side and memory-side signals of the coherence bus.
// master = bus controller, slave = caches plus memory_control.
interface snoop_bus_ctrl_if
    import snoop_bus_ctrl_pkg::*;
#(
    parameter int CPUS = CPUS_DEF
);

    logic [CPUS-1:0] dREN;
    logic [CPUS-1:0] dWEN;
    logic [CPUS-1:0] cctrans;
    logic [CPUS-1:0] ccwrite;
    logic [CPUS-1:0] dwait;
    logic [CPUS-1:0] ccwait;
    logic [CPUS-1:0] ccinv;
    word_t           daddr       [CPUS];
    word_t           dstore      [CPUS];
    word_t           dload       [CPUS];
    word_t           ccsnoopaddr [CPUS];

    logic  mem_dREN;
    logic  mem_dWEN;
    logic  mem_dwait;
    word_t mem_daddr;
    word_t mem_dstore;
    word_t mem_dload;

    modport master (
        input  dREN, dWEN, cctrans, ccwrite, daddr, dstore,
        input  mem_dload, mem_dwait,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr,
        output mem_dREN, mem_dWEN, mem_daddr, mem_dstore
    );

    modport slave (
        output dREN, dWEN, cctrans, ccwrite, daddr, dstore,
        output mem_dload, mem_dwait,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
        input  mem_dREN, mem_dWEN, mem_daddr, mem_dstore
    );

endinterface

// File: rtl/snoop_bus_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer names the preferred CPU
// and moves to the CPU not just served when a transaction finishes.
module snoop_rr_arb (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       served,
    output logic       gnt
);

    logic ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~served;
        end
    end

    assign gnt = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/snoop_bus_ctrl.sv
// MSI snooping bus controller for two dcaches sharing memory_control.
// Define C2C_FORWARD_EN to forward snooped M data straight to the requester.
module snoop_bus_ctrl
    import snoop_bus_ctrl_pkg::*;
#(
    parameter int CPUS     = CPUS_DEF,
    parameter int BLKWORDS = BLKWORDS_DEF
) (
    input logic              CLK,
    input logic              nRST,
    snoop_bus_ctrl_if.master bus
);

    localparam int            CW   = cnt_w(BLKWORDS);
    localparam logic [CW-1:0] LAST = CW'(BLKWORDS - 1);

    generate
        if (CPUS != 2) begin : g_bad_cpus
            $error("snoop_bus_ctrl supports exactly 2 CPUs");
        end
    endgenerate

    busstate_t       state;
    logic            r;
    logic            o;
    logic            armed;
    logic [CW-1:0]   cnt;
    logic [CPUS-1:0] ccwait_q;
    logic [CPUS-1:0] ccinv_q;
    word_t           snp_addr;
    logic [1:0]      req;
    logic            gnt;
    logic            word_done;
    logic            last_word;

    assign o         = ~r;
    assign req       = bus.cctrans | bus.dWEN;
    assign word_done = ~bus.mem_dwait;
    assign last_word = word_done && (cnt == LAST);

    snoop_rr_arb u_arb (
        .CLK     (CLK),
        .nRST    (nRST),
        .req     (req),
        .advance (state == DONE),
        .served  (r),
        .gnt     (gnt)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            r        <= 1'b0;
            armed    <= 1'b0;
            cnt      <= '0;
            ccwait_q <= '0;
            ccinv_q  <= '0;
            snp_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|req) begin
                        r <= gnt;
                        if (bus.cctrans[gnt]) begin
                            state           <= SNOOP;
                            armed           <= 1'b0;
                            ccwait_q[~gnt]  <= 1'b1;
                            ccinv_q[~gnt]   <= bus.ccwrite[gnt];
                            snp_addr        <= bus.daddr[gnt];
                        end else begin
                            state <= WB;
                        end
                    end
                end
                SNOOP: begin
                    // ignore the first cycle so a stale cctrans is not taken as ack
                    armed <= 1'b1;
                    if (armed && bus.cctrans[o]) begin
                        if (!bus.dREN[r]) begin
                            state    <= DONE;
                            ccwait_q <= '0;
                            ccinv_q  <= '0;
                        end else if (bus.ccwrite[o]) begin
                            state <= SUPPLY;
                        end else begin
                            state <= MEMRD;
                        end
                    end
                end
                WB, MEMRD: begin
                    if (word_done) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (last_word) begin
                        cnt      <= '0;
                        state    <= DONE;
                        ccwait_q <= '0;
                        ccinv_q  <= '0;
                    end
                end
                SUPPLY: begin
                    if (word_done) begin
                        cnt <= cnt + CW'(1);
                    end
                    if (last_word) begin
                        cnt <= '0;
`ifdef C2C_FORWARD_EN
                        state    <= DONE;
                        ccwait_q <= '0;
                        ccinv_q  <= '0;
`else
                        state <= MEMRD;
`endif
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    ccwait_q <= '0;
                    ccinv_q  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.dwait      = '1;
        bus.ccwait     = ccwait_q;
        bus.ccinv      = ccinv_q;
        bus.mem_dREN   = 1'b0;
        bus.mem_dWEN   = 1'b0;
        bus.mem_daddr  = '0;
        bus.mem_dstore = '0;
        for (int i = 0; i < CPUS; i++) begin
            bus.dload[i]       = '0;
            bus.ccsnoopaddr[i] = ccwait_q[i] ? snp_addr : '0;
        end
        case (state)
            WB: begin
                bus.mem_dWEN   = 1'b1;
                bus.mem_daddr  = bus.daddr[r];
                bus.mem_dstore = bus.dstore[r];
                bus.dwait[r]   = bus.mem_dwait;
            end
            MEMRD: begin
                bus.mem_dREN  = 1'b1;
                bus.mem_daddr = bus.daddr[r];
                bus.dload[r]  = bus.mem_dload;
                bus.dwait[r]  = bus.mem_dwait;
            end
            SUPPLY: begin
                bus.mem_dWEN   = 1'b1;
                bus.mem_daddr  = bus.daddr[o];
                bus.mem_dstore = bus.dstore[o];
                bus.dwait[o]   = bus.mem_dwait;
`ifdef C2C_FORWARD_EN
                bus.dload[r] = bus.dstore[o];
                bus.dwait[r] = bus.mem_dwait;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule
